// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the native/AXI-Lite register path:
// FSM encoding, response and protection constants, word-to-byte address helper.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // Word address to 32-bit-word-aligned byte address; callers truncate to their AXI width.
  function automatic logic [63:0] word_to_byte_addr(input logic [61:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/native_axil_master.sv
// Native single-beat request port to AXI4-Lite master bridge: one AXI write or
// read per accepted request, completion reported by a one-cycle NATIVE_READY.
module native_axil_master
  import axi_lite_pkg::*;
#(
  parameter int NATIVE_ADDR_WIDTH = 1,
  parameter int NATIVE_DATA_WIDTH = 32,
  parameter int M_AXI_ADDR_WIDTH  = 3,
  parameter int M_AXI_DATA_WIDTH  = 32
) (
  input  logic                          M_AXI_aclk,
  input  logic                          M_AXI_areset,

  input  logic                          NATIVE_EN,
  input  logic                          NATIVE_WR,
  input  logic [NATIVE_ADDR_WIDTH-1:0]  NATIVE_ADDR,
  input  logic [NATIVE_DATA_WIDTH-1:0]  NATIVE_DATA_IN,
  output logic [NATIVE_DATA_WIDTH-1:0]  NATIVE_DATA_OUT,
  output logic                          NATIVE_READY,
  output logic                          NATIVE_ERR,
  output logic                          NATIVE_BUSY,

  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic                          M_AXI_awvalid,
  input  logic                          M_AXI_awready,
  output logic [2:0]                    M_AXI_awprot,

  output logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                          M_AXI_wvalid,
  input  logic                          M_AXI_wready,

  input  logic [1:0]                    M_AXI_bresp,
  input  logic                          M_AXI_bvalid,
  output logic                          M_AXI_bready,

  output logic [M_AXI_ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic                          M_AXI_arvalid,
  input  logic                          M_AXI_arready,
  output logic [2:0]                    M_AXI_arprot,

  input  logic [M_AXI_DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]                    M_AXI_rresp,
  input  logic                          M_AXI_rvalid,
  output logic                          M_AXI_rready
);

  state_t                        state;
  state_t                        state_nxt;
  logic [NATIVE_ADDR_WIDTH-1:0]  addr_q;
  logic [NATIVE_DATA_WIDTH-1:0]  data_q;
  logic [NATIVE_DATA_WIDTH-1:0]  data_out_q;
  logic                          aw_done_q;
  logic                          w_done_q;
  logic                          err_q;
  logic                          aw_hs;
  logic                          w_hs;
  logic                          accept;

  assign accept = (state == ST_IDLE) && NATIVE_EN;
  assign aw_hs  = M_AXI_awvalid && M_AXI_awready;
  assign w_hs   = M_AXI_wvalid && M_AXI_wready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge M_AXI_aclk or posedge M_AXI_areset) begin
    if (M_AXI_areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (NATIVE_EN) state_nxt = NATIVE_WR ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_nxt = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (M_AXI_bvalid) state_nxt = ST_DONE;
      end
      ST_RD_REQ: begin
        if (M_AXI_arready) state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (M_AXI_rvalid) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request holding registers, per-channel write completion and response capture.
  always_ff @(posedge M_AXI_aclk or posedge M_AXI_areset) begin
    if (M_AXI_areset) begin
      addr_q     <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= NATIVE_ADDR;
        data_q    <= NATIVE_DATA_IN;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        err_q     <= 1'b0;
      end
      if (state == ST_WR_REQ) begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if ((state == ST_WR_RESP) && M_AXI_bvalid) begin
        err_q <= (M_AXI_bresp != RESP_OKAY);
      end
      if ((state == ST_RD_DATA) && M_AXI_rvalid) begin
        data_out_q <= M_AXI_rdata[NATIVE_DATA_WIDTH-1:0];
        err_q      <= (M_AXI_rresp != RESP_OKAY);
      end
    end
  end

  // Handshake controls decode straight from state so reset clears them asynchronously.
  always_comb begin
    M_AXI_awvalid = 1'b0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_wstrb   = '0;
    M_AXI_bready  = 1'b0;
    M_AXI_arvalid = 1'b0;
    M_AXI_rready  = 1'b0;
    NATIVE_READY  = 1'b0;
    NATIVE_BUSY   = 1'b0;
    case (state)
      ST_WR_REQ: begin
        M_AXI_awvalid = !aw_done_q;
        M_AXI_wvalid  = !w_done_q;
        M_AXI_wstrb   = '1;
        NATIVE_BUSY   = 1'b1;
      end
      ST_WR_RESP: begin
        M_AXI_bready = 1'b1;
        NATIVE_BUSY  = 1'b1;
      end
      ST_RD_REQ: begin
        M_AXI_arvalid = 1'b1;
        NATIVE_BUSY   = 1'b1;
      end
      ST_RD_DATA: begin
        M_AXI_rready = 1'b1;
        NATIVE_BUSY  = 1'b1;
      end
      ST_DONE: NATIVE_READY = 1'b1;
      default: ;
    endcase
  end

  assign M_AXI_awaddr    = M_AXI_ADDR_WIDTH'(word_to_byte_addr(62'(addr_q)));
  assign M_AXI_araddr    = M_AXI_ADDR_WIDTH'(word_to_byte_addr(62'(addr_q)));
  assign M_AXI_awprot    = PROT_DEFAULT;
  assign M_AXI_arprot    = PROT_DEFAULT;
  assign M_AXI_wdata     = M_AXI_DATA_WIDTH'(data_q);
  assign NATIVE_DATA_OUT = data_out_q;
  assign NATIVE_ERR      = err_q;

endmodule

// File: tb/tb_native_axil_master.sv
// Self-checking bench for native_axil_master: a reactive AXI-Lite slave with
// per-transaction delays, plus a scoreboard of expected completions.
module tb_native_axil_master;
  import axi_lite_pkg::*;

  localparam int NAW = 1;
  localparam int NDW = 32;
  localparam int MAW = 3;
  localparam int MDW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           native_en;
  logic           native_wr;
  logic [NAW-1:0] native_addr;
  logic [NDW-1:0] native_data_in;
  logic [NDW-1:0] native_data_out;
  logic           native_ready;
  logic           native_err;
  logic           native_busy;
  logic [MAW-1:0] awaddr;
  logic           awvalid;
  logic           awready;
  logic [2:0]     awprot;
  logic [MDW-1:0] wdata;
  logic [MDW/8-1:0] wstrb;
  logic           wvalid;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [MAW-1:0] araddr;
  logic           arvalid;
  logic           arready;
  logic [2:0]     arprot;
  logic [MDW-1:0] rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready;

  always #5 clk = ~clk;

  native_axil_master #(
    .NATIVE_ADDR_WIDTH(NAW), .NATIVE_DATA_WIDTH(NDW),
    .M_AXI_ADDR_WIDTH(MAW),  .M_AXI_DATA_WIDTH(MDW)
  ) dut (
    .M_AXI_aclk(clk), .M_AXI_areset(rst),
    .NATIVE_EN(native_en), .NATIVE_WR(native_wr), .NATIVE_ADDR(native_addr),
    .NATIVE_DATA_IN(native_data_in), .NATIVE_DATA_OUT(native_data_out),
    .NATIVE_READY(native_ready), .NATIVE_ERR(native_err), .NATIVE_BUSY(native_busy),
    .M_AXI_awaddr(awaddr), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready), .M_AXI_awprot(awprot),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_araddr(araddr), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready), .M_AXI_arprot(arprot),
    .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
  );

  typedef struct {
    logic           wr;
    logic [NAW-1:0] addr;
    logic [NDW-1:0] data;
    logic [1:0]     resp;
    logic [MDW-1:0] rdata;
    int             aw_d, w_d, b_d, ar_d, r_d;
  } txn_t;

  typedef struct {
    logic           wr;
    logic           err;
    logic [NDW-1:0] data_out;
  } exp_t;

  exp_t           sb[$];
  txn_t           cur;
  logic [NDW-1:0] model_data_out = '0;
  int             checks   = 0;
  int             failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [NAW-1:0] addr, input logic [NDW-1:0] data,
                              input logic [1:0] resp, input logic [MDW-1:0] rd,
                              input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.resp = resp; t.rdata = rd;
    t.aw_d = aw_d; t.w_d = w_d; t.b_d = b_d; t.ar_d = ar_d; t.r_d = r_d;
    return t;
  endfunction

  // Slave model: ready/valid change only on the falling edge, so a handshake
  // on a rising edge is exactly "both high at the preceding falling edge".
  int   aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int   aw_n, w_n, b_n, ar_n, r_n;
  logic aw_done, w_done, ar_done;
  logic aw_f, w_f, b_f, ar_f, r_f;
  logic aw_h, w_h, ar_h;
  logic [MAW-1:0] exp_ax;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
      aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
      aw_f = 1'b0; w_f = 1'b0; b_f = 1'b0; ar_f = 1'b0; r_f = 1'b0;
      aw_h = 1'b0; w_h = 1'b0; ar_h = 1'b0;
    end else begin
      if (aw_f) begin aw_n++; aw_done = 1'b1; awready = 1'b0; end
      if (w_f)  begin w_n++;  w_done  = 1'b1; wready  = 1'b0; end
      if (b_f)  begin b_n++;  bvalid  = 1'b0; end
      if (ar_f) begin ar_n++; ar_done = 1'b1; arready = 1'b0; end
      if (r_f)  begin r_n++;  rvalid  = 1'b0; end

      if (aw_h) check("awvalid_held", awvalid, 1);
      if (w_h)  check("wvalid_held", wvalid, 1);
      if (ar_h) check("arvalid_held", arvalid, 1);

      if (native_ready) begin
        check("busy_in_ready_cycle", native_busy, 0);
        if (sb.size() == 0) begin
          check("unexpected_ready", native_ready, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("native_err", native_err, e.err);
          check("native_data_out", native_data_out, e.data_out);
          check("aw_handshakes", aw_n, e.wr);
          check("w_handshakes", w_n, e.wr);
          check("b_handshakes", b_n, e.wr);
          check("ar_handshakes", ar_n, !e.wr);
          check("r_handshakes", r_n, !e.wr);
        end
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      end

      exp_ax = '0;
      exp_ax[NAW+1:0] = {cur.addr, 2'b00};

      if (awvalid) begin
        check("awaddr", awaddr, exp_ax);
        check("awprot", awprot, 0);
        if (!awready) begin
          if (aw_wait >= cur.aw_d) awready = 1'b1;
          else aw_wait++;
        end
      end
      if (wvalid) begin
        check("wdata", wdata, MDW'(cur.data));
        check("wstrb", wstrb, {(MDW/8){1'b1}});
        if (!wready) begin
          if (w_wait >= cur.w_d) wready = 1'b1;
          else w_wait++;
        end
      end
      if (bready) check("bready_after_aw_and_w", aw_done && w_done, 1);
      if (aw_done && w_done && !bvalid && b_n == 0) begin
        if (b_wait >= cur.b_d) begin bvalid = 1'b1; bresp = cur.resp; end
        else b_wait++;
      end

      if (arvalid) begin
        check("araddr", araddr, exp_ax);
        check("arprot", arprot, 0);
        if (!arready) begin
          if (ar_wait >= cur.ar_d) arready = 1'b1;
          else ar_wait++;
        end
      end
      if (rready) check("rready_after_ar", ar_done, 1);
      if (ar_done && !rvalid && r_n == 0) begin
        if (r_wait >= cur.r_d) begin rvalid = 1'b1; rdata = cur.rdata; rresp = cur.resp; end
        else r_wait++;
      end

      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      b_f  = bvalid && bready;
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      aw_h = awvalid && !awready;
      w_h  = wvalid && !wready;
      ar_h = arvalid && !arready;
    end
  end

  // Drives one request, records its expected completion, waits for NATIVE_READY.
  task automatic issue(input txn_t t, input bit stray, input bit chk_lat);
    exp_t e;
    int   lat;
    cur = t;
    if (!t.wr) model_data_out = t.rdata[NDW-1:0];
    e.wr = t.wr;
    e.err = (t.resp != RESP_OKAY);
    e.data_out = model_data_out;
    sb.push_back(e);
    @(negedge clk);
    native_en = 1'b1; native_wr = t.wr; native_addr = t.addr; native_data_in = t.data;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        native_en = 1'b0;
        check("busy_after_accept", native_busy, 1);
      end
      if (stray && lat == 2) begin
        native_en = 1'b1; native_wr = 1'b1; native_data_in = 32'h1;
      end
      if (stray && lat == 3) native_en = 1'b0;
    end while (!native_ready && lat < 200);
    check("ready_seen", native_ready, 1);
    if (chk_lat) check("latency_cycles", lat, 3);
    native_en = 1'b0;
  endtask

  initial begin
    native_en = 1'b0; native_wr = 1'b0; native_addr = '0; native_data_in = '0;
    cur = mk(1'b0, '0, '0, RESP_OKAY, '0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, native_ready, native_busy, native_err}, 0);
    check("reset_addr_strb", {awaddr, araddr, wstrb, awprot, arprot}, 0);
    check("reset_data_out", native_data_out, 0);
    check("reset_wdata", wdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(mk(1'b1, 1'b1, 32'hDEADBEEF, RESP_OKAY, '0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    issue(mk(1'b0, 1'b0, '0, RESP_OKAY, 32'hCAFEF00D, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    issue(mk(1'b0, 1'b1, '0, RESP_OKAY, 32'h12345678, 0, 0, 0, 4, 2), 1'b0, 1'b0);
    issue(mk(1'b1, 1'b0, 32'h55AA33CC, RESP_OKAY, '0, 3, 0, 0, 0, 0), 1'b0, 1'b0);
    issue(mk(1'b1, 1'b1, 32'h0F0F0F0F, RESP_OKAY, '0, 0, 3, 1, 0, 0), 1'b0, 1'b0);
    issue(mk(1'b1, 1'b0, 32'h11112222, RESP_SLVERR, '0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    issue(mk(1'b0, 1'b1, '0, RESP_DECERR, 32'h000000A5, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    issue(mk(1'b1, 1'b1, 32'h33334444, RESP_OKAY, '0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    issue(mk(1'b0, 1'b0, '0, RESP_OKAY, 32'h0BADF00D, 0, 0, 0, 3, 1), 1'b1, 1'b0);
    repeat (5) @(negedge clk);

    // Reset while a write is stalled on both AW and W.
    cur = mk(1'b1, 1'b1, 32'h77778888, RESP_OKAY, '0, 20, 20, 0, 0, 0);
    native_en = 1'b1; native_wr = 1'b1; native_addr = 1'b1; native_data_in = 32'h77778888;
    @(negedge clk);
    native_en = 1'b0;
    repeat (2) @(negedge clk);
    check("awvalid_before_reset", awvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_ctrl", {awvalid, wvalid, bready, arvalid, rready, native_ready, native_busy, native_err}, 0);
    check("midrst_addr_strb", {awaddr, araddr, wstrb}, 0);
    check("midrst_data_out", native_data_out, 0);
    check("midrst_wdata", wdata, 0);
    model_data_out = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_reset", native_busy, 0);

    issue(mk(1'b0, 1'b1, '0, RESP_OKAY, 32'h600DCAFE, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
